ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester arbiter and sequencer for the single-port data RAM (`ram`, AWIDTH=8, DWIDTH=16). It accepts read/write requests from two masters, for example the load/store unit and a debug/DMA port. It grants one request at a time with round-robin fairness and drives the RAM's read/write strobes and addresses. It returns registered read data to the winning requester. It sits between the masters and the RAM instance and is the only block that drives RAM control inputs.

## Interface
- `AWIDTH`, 8, RAM address width.
- `DWIDTH`, 16, RAM data width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_req0`/`i_req1`  in  1  request from master 0/1; held high until the matching `o_gnt`.
- `i_we0`/`i_we1`  in  1  1 = write, 0 = read.
- `i_addr0`/`i_addr1`  in  AWIDTH  access address.
- `i_wdata0`/`i_wdata1`  in  DWIDTH  write data.
- `o_gnt0`/`o_gnt1`  out  1  one-cycle pulse: request accepted and latched.
- `o_valid0`/`o_valid1`  out  1  one-cycle pulse: `o_rdataN` holds the read result.
- `o_rdata0`/`o_rdata1`  out  DWIDTH  read data; holds the value until the next read completes for that master.
- `o_ram_rd`, `o_ram_wr`  out  1  RAM strobes; never high together.
- `o_ram_raddr`, `o_ram_waddr`  out  AWIDTH  RAM addresses.
- `o_ram_wdata`  out  DWIDTH  RAM write data.
- `i_ram_rdata`  in  DWIDTH  RAM registered read data; valid the cycle after `o_ram_rd`.
- `o_busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ISSUE, CAPTURE.
- IDLE: if any `i_reqN` is high, select a winner. Latch its we/addr/wdata and its index into `sel`, then go to ISSUE. Otherwise stay in IDLE.
- Arbitration: a single requester wins unconditionally. If both request, the winner is the master not equal to `last`. `last` updates to the winner on every grant and resets to 1, so master 0 wins first after reset.
- ISSUE, write: `o_ram_wr`=1 with `o_ram_waddr`/`o_ram_wdata` from the latch and `o_ram_rd`=0. Next state is IDLE.
- ISSUE, read: `o_ram_rd`=1 with `o_ram_raddr` from the latch and `o_ram_wr`=0. Next state is CAPTURE.
- CAPTURE: register `i_ram_rdata` into `o_rdata[sel]`, set `o_valid[sel]` for the next cycle, then go to IDLE.
- In IDLE and CAPTURE, `o_ram_rd`=`o_ram_wr`=0.
- Both address outputs carry the latched address during ISSUE. Otherwise they hold their last value.
- All outputs are registered. `o_gntN` and `o_validN` are single-cycle pulses; at most one of each pair is high in any cycle.
- Requests may arrive in any state but are only evaluated in IDLE. A request arriving during ISSUE/CAPTURE waits without loss.
- After `o_gntN`, the master may drop its request or change its inputs immediately. If `i_reqN` is still high in the next IDLE, that is a new request.

## Timing
- Reset (asynchronous, `rst`=0): state IDLE, `last`=1. All outputs are 0, including `o_rdata0/1`. An in-flight read is discarded and no `o_valid` is produced.
- Request sampled in IDLE at cycle T: `o_gntN` and the RAM strobe are both high in cycle T+1 (ISSUE).
- Write: occupies T+1 only. A new request can be sampled in T+2, giving 2 cycles per write under back-to-back load.
- Read: strobe in T+1, RAM data in T+2 (CAPTURE), `o_validN`=1 and `o_rdataN` valid in T+3. The arbiter is in IDLE in T+3 and can sample there, giving 3 cycles per read.
- `o_busy` is high in ISSUE and CAPTURE.

## Test plan
- Reset: hold `rst`=0 with random requests. All outputs must be 0. Release `rst` with no requests: state stays IDLE, `o_busy`=0, no strobes.
- Single write: master 0 writes 0xBEEF to 0x12. The cycle after sampling must show `o_gnt0`=1, `o_ram_wr`=1, `o_ram_waddr`=0x12, `o_ram_wdata`=0xBEEF, `o_ram_rd`=0, for exactly one cycle.
- Read back: master 1 reads 0x12 with the RAM model returning 0xBEEF. Expect `o_ram_rd` at T+1 and `o_valid1`=1 with `o_rdata1`=0xBEEF at T+3. `o_rdata0` must be unchanged.
- Fairness: both masters request continuous writes after reset. Grants must alternate 0,1,0,1,… every 2 cycles, never the same master twice in a row.
- Reset mid-read: assert `rst` during CAPTURE. No `o_valid` pulse, `o_rdataN`=0. After release, a new read completes normally.
- Held request: master 0 alone holds `i_req0`=1 with `i_we0`=0. Reads issue every 3 cycles with `o_valid0` pulses at a 3-cycle period, and `o_ram_rd`/`o_ram_wr` are never high together.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter/sequencer for the single-port data RAM; grant+strobe 1 cycle after IDLE sample, read data 3 cycles.
// No backpressure: masters hold i_reqN until o_gntN; requests seen while busy wait for the next IDLE.
module ram_arbiter #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [AWIDTH-1:0] i_addr0,
    input  logic [AWIDTH-1:0] i_addr1,
    input  logic [DWIDTH-1:0] i_wdata0,
    input  logic [DWIDTH-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_valid0,
    output logic              o_valid1,
    output logic [DWIDTH-1:0] o_rdata0,
    output logic [DWIDTH-1:0] o_rdata1,
    output logic              o_ram_rd,
    output logic              o_ram_wr,
    output logic [AWIDTH-1:0] o_ram_raddr,
    output logic [AWIDTH-1:0] o_ram_waddr,
    output logic [DWIDTH-1:0] o_ram_wdata,
    input  logic [DWIDTH-1:0] i_ram_rdata,
    output logic              o_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t state;
    logic   last;
    logic   sel;
    logic   lat_we;

    logic              win;
    logic              win_we;
    logic [AWIDTH-1:0] win_addr;
    logic [DWIDTH-1:0] win_wdata;

    // On contention the master that did not win last time goes next
    assign win       = (i_req0 && i_req1) ? ~last : i_req1;
    assign win_we    = win ? i_we1    : i_we0;
    assign win_addr  = win ? i_addr1  : i_addr0;
    assign win_wdata = win ? i_wdata1 : i_wdata0;

    assign o_busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last        <= 1'b1;
            sel         <= 1'b0;
            lat_we      <= 1'b0;
            o_gnt0      <= 1'b0;
            o_gnt1      <= 1'b0;
            o_valid0    <= 1'b0;
            o_valid1    <= 1'b0;
            o_rdata0    <= '0;
            o_rdata1    <= '0;
            o_ram_rd    <= 1'b0;
            o_ram_wr    <= 1'b0;
            o_ram_raddr <= '0;
            o_ram_waddr <= '0;
            o_ram_wdata <= '0;
        end else begin
            o_gnt0   <= 1'b0;
            o_gnt1   <= 1'b0;
            o_valid0 <= 1'b0;
            o_valid1 <= 1'b0;
            o_ram_rd <= 1'b0;
            o_ram_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req0 || i_req1) begin
                        sel         <= win;
                        last        <= win;
                        lat_we      <= win_we;
                        o_gnt0      <= ~win;
                        o_gnt1      <= win;
                        o_ram_wr    <= win_we;
                        o_ram_rd    <= ~win_we;
                        o_ram_raddr <= win_addr;
                        o_ram_waddr <= win_addr;
                        if (win_we) begin
                            o_ram_wdata <= win_wdata;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= lat_we ? IDLE : CAPTURE;
                end
                CAPTURE: begin
                    // RAM output register is valid now; present it to the owner next cycle
                    if (sel) begin
                        o_rdata1 <= i_ram_rdata;
                        o_valid1 <= 1'b1;
                    end else begin
                        o_rdata0 <= i_ram_rdata;
                        o_valid0 <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed steps plus random traffic checked against a transaction-level schedule model.
module tb_ram_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req   [2];
    logic          we    [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];

    logic          o_gnt0, o_gnt1, o_valid0, o_valid1;
    logic [DW-1:0] o_rdata0, o_rdata1;
    logic          o_ram_rd, o_ram_wr;
    logic [AW-1:0] o_ram_raddr, o_ram_waddr;
    logic [DW-1:0] o_ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          o_busy;

    ram_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .i_req0(req[0]), .i_req1(req[1]),
        .i_we0(we[0]), .i_we1(we[1]),
        .i_addr0(addr[0]), .i_addr1(addr[1]),
        .i_wdata0(wdata[0]), .i_wdata1(wdata[1]),
        .o_gnt0(o_gnt0), .o_gnt1(o_gnt1),
        .o_valid0(o_valid0), .o_valid1(o_valid1),
        .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
        .o_ram_rd(o_ram_rd), .o_ram_wr(o_ram_wr),
        .o_ram_raddr(o_ram_raddr), .o_ram_waddr(o_ram_waddr),
        .o_ram_wdata(o_ram_wdata),
        .i_ram_rdata(ram_rdata),
        .o_busy(o_busy)
    );

    // Single-port RAM with registered read data
    bit [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (o_ram_wr) mem[o_ram_waddr] <= o_ram_wdata;
        if (o_ram_rd) ram_rdata <= mem[o_ram_raddr];
    end

    int checks = 0;
    int failures = 0;

    // Reference model: one entry per clock edge (ring of 64) of what the outputs must show after it
    bit [DW-1:0] model_mem [256];
    int          e;
    int          free_at;
    int          last_w;
    int          granted_at [2];
    bit          ev_gnt  [2][64];
    bit          ev_val  [2][64];
    bit          ev_rd   [64];
    bit          ev_wr   [64];
    bit          ev_busy [64];
    bit          ev_aset [64];
    logic [AW-1:0] ev_addr [64];
    logic [DW-1:0] ev_wd   [64];
    logic [DW-1:0] ev_rdat [64];
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_rdata [2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        assert (act === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            ev_gnt[0][i] = 0; ev_gnt[1][i] = 0; ev_val[0][i] = 0; ev_val[1][i] = 0;
            ev_rd[i] = 0; ev_wr[i] = 0; ev_busy[i] = 0; ev_aset[i] = 0;
        end
        free_at = 0;
        last_w = 1;
        granted_at[0] = -1;
        granted_at[1] = -1;
        exp_addr = '0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
    endtask

    // Decide what the arbiter does with the inputs sampled at edge s
    task automatic model_eval(input int s);
        int w;
        int i;
        i = s % 64;
        if (s >= free_at && (req[0] || req[1])) begin
            if (req[0] && req[1]) w = (last_w == 1) ? 0 : 1;
            else                  w = req[1] ? 1 : 0;
            last_w = w;
            granted_at[w] = s;
            ev_gnt[w][i] = 1;
            ev_busy[i] = 1;
            ev_aset[i] = 1;
            ev_addr[i] = addr[w];
            if (we[w]) begin
                ev_wr[i] = 1;
                ev_wd[i] = wdata[w];
                model_mem[addr[w]] = wdata[w];
                free_at = s + 2;
            end else begin
                ev_rd[i] = 1;
                ev_busy[(s + 1) % 64] = 1;
                ev_val[w][(s + 2) % 64] = 1;
                ev_rdat[(s + 2) % 64] = model_mem[addr[w]];
                free_at = s + 3;
            end
        end
    endtask

    task automatic model_check(input int n);
        int i;
        i = n % 64;
        if (ev_aset[i]) exp_addr = ev_addr[i];
        if (ev_val[0][i]) exp_rdata[0] = ev_rdat[i];
        if (ev_val[1][i]) exp_rdata[1] = ev_rdat[i];
        chk("gnt0", o_gnt0, ev_gnt[0][i]);
        chk("gnt1", o_gnt1, ev_gnt[1][i]);
        chk("ram_rd", o_ram_rd, ev_rd[i]);
        chk("ram_wr", o_ram_wr, ev_wr[i]);
        chk("rdwr_excl", o_ram_rd & o_ram_wr, 0);
        chk("raddr", o_ram_raddr, exp_addr);
        chk("waddr", o_ram_waddr, exp_addr);
        if (ev_wr[i]) chk("wdata", o_ram_wdata, ev_wd[i]);
        chk("valid0", o_valid0, ev_val[0][i]);
        chk("valid1", o_valid1, ev_val[1][i]);
        chk("rdata0", o_rdata0, exp_rdata[0]);
        chk("rdata1", o_rdata1, exp_rdata[1]);
        chk("busy", o_busy, ev_busy[i]);
        ev_gnt[0][i] = 0; ev_gnt[1][i] = 0; ev_val[0][i] = 0; ev_val[1][i] = 0;
        ev_rd[i] = 0; ev_wr[i] = 0; ev_busy[i] = 0; ev_aset[i] = 0;
    endtask

    task automatic cycle();
        model_eval(e + 1);
        @(posedge clk);
        e++;
        @(negedge clk);
        model_check(e);
    endtask

    // Masters: release a granted request, then maybe raise a new one (p = percent chance)
    task automatic drive(input int p0, input int p1, input int wm);
        int p [2];
        p[0] = p0;
        p[1] = p1;
        for (int w = 0; w < 2; w++) begin
            if (req[w] && granted_at[w] == e) req[w] = 1'b0;
            if (!req[w] && int'($urandom_range(0, 99)) < p[w]) begin
                req[w]   = 1'b1;
                we[w]    = (wm == 2) ? 1'($urandom_range(0, 1)) : wm[0];
                addr[w]  = AW'($urandom_range(0, 15));
                wdata[w] = DW'($urandom);
            end
        end
    endtask

    task automatic zero_chk();
        chk("rst_gnt0", o_gnt0, 0);
        chk("rst_gnt1", o_gnt1, 0);
        chk("rst_valid0", o_valid0, 0);
        chk("rst_valid1", o_valid1, 0);
        chk("rst_rdata0", o_rdata0, 0);
        chk("rst_rdata1", o_rdata1, 0);
        chk("rst_ram_rd", o_ram_rd, 0);
        chk("rst_ram_wr", o_ram_wr, 0);
        chk("rst_raddr", o_ram_raddr, 0);
        chk("rst_waddr", o_ram_waddr, 0);
        chk("rst_wdata", o_ram_wdata, 0);
        chk("rst_busy", o_busy, 0);
    endtask

    task automatic reset_phase(input int n);
        rst = 1'b0;
        #1;
        zero_chk();
        repeat (n) begin
            for (int w = 0; w < 2; w++) begin
                req[w]   = 1'($urandom_range(0, 1));
                we[w]    = 1'($urandom_range(0, 1));
                addr[w]  = AW'($urandom);
                wdata[w] = DW'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            zero_chk();
        end
        req[0] = 1'b0;
        req[1] = 1'b0;
        model_reset();
        rst = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int exp_next;
        int last_g;
        int last_v;

        rst = 1'b1;
        e = 0;
        for (int w = 0; w < 2; w++) begin
            req[w] = 1'b0; we[w] = 1'b0; addr[w] = '0; wdata[w] = '0;
        end
        model_reset();
        #2;
        reset_phase(4);
        repeat (3) cycle();

        // Single write from master 0
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h12; wdata[0] = 16'hBEEF;
        cycle();
        chk("wr_gnt0", o_gnt0, 1);
        chk("wr_strobe", o_ram_wr, 1);
        chk("wr_waddr", o_ram_waddr, 8'h12);
        chk("wr_wdata", o_ram_wdata, 16'hBEEF);
        chk("wr_no_rd", o_ram_rd, 0);
        req[0] = 1'b0;
        cycle();
        chk("wr_one_cycle", o_ram_wr, 0);

        // Read back through master 1
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h12;
        cycle();
        chk("rb_rd", o_ram_rd, 1);
        req[1] = 1'b0;
        cycle();
        cycle();
        chk("rb_valid1", o_valid1, 1);
        chk("rb_rdata1", o_rdata1, 16'hBEEF);
        chk("rb_rdata0", o_rdata0, 0);

        // Random mixed traffic, then drain
        repeat (300) begin drive(50, 50, 2); cycle(); end
        repeat (10) begin drive(0, 0, 2); cycle(); end

        // Fairness: both masters write back-to-back from reset
        reset_phase(2);
        exp_next = 0;
        last_g = -1;
        repeat (40) begin
            drive(100, 100, 1);
            cycle();
            if (o_gnt0 || o_gnt1) begin
                chk("fair_order", o_gnt1, exp_next);
                if (last_g >= 0) chk("fair_period", e - last_g, 2);
                exp_next ^= 1;
                last_g = e;
            end
        end
        repeat (10) begin drive(0, 0, 2); cycle(); end

        // Reset while the arbiter is in CAPTURE
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h12;
        cycle();
        req[1] = 1'b0;
        cycle();
        chk("mr_busy", o_busy, 1);
        reset_phase(2);
        cycle();
        cycle();
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h12;
        cycle();
        req[1] = 1'b0;
        cycle();
        cycle();
        chk("mr_valid1", o_valid1, 1);

        // Master 0 holds a read request continuously
        last_v = -1;
        repeat (24) begin
            drive(100, 0, 0);
            cycle();
            if (o_valid0) begin
                if (last_v >= 0) chk("held_period", e - last_v, 3);
                last_v = e;
            end
        end
        repeat (10) begin drive(0, 0, 2); cycle(); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
